// File: rtl/inta_sequencer_if.sv
// Bus bundle between the PIC-side INTA responder, the core and inta_sequencer.
`timescale 1ns / 1ps

interface inta_sequencer_if;
  logic       INT;
  logic       intEnable;
  logic [7:0] dataBus;
  logic       vectorAck;
  logic       INTA_n;
  logic [7:0] vectorOut;
  logic       vectorValid;
  logic       busy;

  modport master (
    input  INT, intEnable, dataBus, vectorAck,
    output INTA_n, vectorOut, vectorValid, busy
  );

  modport slave (
    output INT, intEnable, dataBus, vectorAck,
    input  INTA_n, vectorOut, vectorValid, busy
  );
endinterface

// File: rtl/inta_sequencer.sv
// 8259A interrupt-acknowledge initiator: two INTA_n pulses, vector capture, valid/ack hand-off.
// Build option INTA_INT_SYNC_EN adds a two-flop synchronizer on INT.
`timescale 1ns / 1ps

module inta_sequencer #(
  parameter int unsigned PULSE_CYCLES = 2,
  parameter int unsigned GAP_CYCLES   = 2
) (
  input logic              clk,
  input logic              reset,
  inta_sequencer_if.master bus
);

  localparam int unsigned CntMax = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
  localparam int unsigned CntW   = $clog2(CntMax) + 1;
  localparam logic [CntW-1:0] PulseLoad = CntW'(PULSE_CYCLES);
  localparam logic [CntW-1:0] GapLoad   = CntW'(GAP_CYCLES);
  localparam logic [CntW-1:0] CntOne    = CntW'(1);

  typedef enum logic [2:0] {StIdle, StAck1, StGap, StAck2, StHold} state_t;

  state_t          state;
  logic [CntW-1:0] count;
  logic            intSampled;

`ifdef INTA_INT_SYNC_EN
  logic [1:0] intSync;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      intSync <= 2'b00;
    end else begin
      intSync <= {intSync[0], bus.INT};
    end
  end

  assign intSampled = intSync[1];
`else
  assign intSampled = bus.INT;
`endif

  // Once ACK1 is entered the sequence runs to completion regardless of INT/intEnable.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= StIdle;
      count           <= '0;
      bus.INTA_n      <= 1'b1;
      bus.vectorOut   <= 8'h00;
      bus.vectorValid <= 1'b0;
      bus.busy        <= 1'b0;
    end else begin
      case (state)
        StIdle: begin
          if (intSampled && bus.intEnable) begin
            state      <= StAck1;
            count      <= PulseLoad;
            bus.INTA_n <= 1'b0;
            bus.busy   <= 1'b1;
          end
        end
        StAck1: begin
          if (count == CntOne) begin
            state      <= StGap;
            count      <= GapLoad;
            bus.INTA_n <= 1'b1;
          end else begin
            count <= count - CntOne;
          end
        end
        StGap: begin
          if (count == CntOne) begin
            state      <= StAck2;
            count      <= PulseLoad;
            bus.INTA_n <= 1'b0;
          end else begin
            count <= count - CntOne;
          end
        end
        StAck2: begin
          if (count == CntOne) begin
            state           <= StHold;
            count           <= '0;
            bus.INTA_n      <= 1'b1;
            bus.vectorOut   <= bus.dataBus;
            bus.vectorValid <= 1'b1;
          end else begin
            count <= count - CntOne;
          end
        end
        StHold: begin
          // Ack is only seen from the cycle after entry, so HOLD lasts at least one cycle.
          if (bus.vectorAck) begin
            state           <= StIdle;
            bus.vectorValid <= 1'b0;
            bus.busy        <= 1'b0;
          end
        end
        default: begin
          state           <= StIdle;
          count           <= '0;
          bus.INTA_n      <= 1'b1;
          bus.vectorValid <= 1'b0;
          bus.busy        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inta_sequencer.sv
// Directed bench for inta_sequencer: default instance (2/2) and a 3/1 instance.
`timescale 1ns / 1ps

module tb_inta_sequencer;

`ifdef INTA_INT_SYNC_EN
  localparam int SyncLat = 2;
`else
  localparam int SyncLat = 0;
`endif

  logic clk = 1'b0;
  logic reset;
  int   nVec  = 0;
  int   nFail = 0;

  always #5 clk = ~clk;

  inta_sequencer_if busA ();
  inta_sequencer_if busB ();

  inta_sequencer #(.PULSE_CYCLES(2), .GAP_CYCLES(2)) dutA (
    .clk   (clk),
    .reset (reset),
    .bus   (busA)
  );

  inta_sequencer #(.PULSE_CYCLES(3), .GAP_CYCLES(1)) dutB (
    .clk   (clk),
    .reset (reset),
    .bus   (busB)
  );

  // Expected INTA_n at edge k, where edge `off` is the one that starts ACK1.
  function automatic logic expInta(int k, int off, int p, int g);
    int j;
    j = k - off;
    return !((j >= 0 && j < p) || (j >= p + g && j < 2 * p + g));
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    busA.INT = 0; busA.intEnable = 0; busA.dataBus = 8'h00; busA.vectorAck = 0;
    busB.INT = 0; busB.intEnable = 0; busB.dataBus = 8'h00; busB.vectorAck = 0;
    tick();
    tick();
    nVec++; if (busA.INTA_n !== 1'b1) begin nFail++; $display("FAIL rstIntaA got %b want 1", busA.INTA_n); end
    nVec++; if (busA.vectorValid !== 1'b0) begin nFail++; $display("FAIL rstValidA got %b want 0", busA.vectorValid); end
    nVec++; if (busA.busy !== 1'b0) begin nFail++; $display("FAIL rstBusyA got %b want 0", busA.busy); end
    nVec++; if (busA.vectorOut !== 8'h00) begin nFail++; $display("FAIL rstVecA got %h want 00", busA.vectorOut); end
    nVec++; if (busB.INTA_n !== 1'b1) begin nFail++; $display("FAIL rstIntaB got %b want 1", busB.INTA_n); end
    nVec++; if (busB.vectorValid !== 1'b0) begin nFail++; $display("FAIL rstValidB got %b want 0", busB.vectorValid); end
    reset = 1'b0;
  endtask

  task automatic test_basic();
    busA.INT = 1; busA.intEnable = 1; busA.dataBus = 8'h48;
    for (int k = 0; k <= SyncLat + 6; k++) begin
      tick();
      nVec++; if (busA.INTA_n !== expInta(k, SyncLat, 2, 2)) begin nFail++; $display("FAIL basicInta k=%0d got %b want %b", k, busA.INTA_n, expInta(k, SyncLat, 2, 2)); end
      nVec++; if (busA.busy !== (k >= SyncLat)) begin nFail++; $display("FAIL basicBusy k=%0d got %b want %b", k, busA.busy, k >= SyncLat); end
      nVec++; if (busA.vectorValid !== (k == SyncLat + 6)) begin nFail++; $display("FAIL basicValid k=%0d got %b", k, busA.vectorValid); end
      if (k == SyncLat + 1) busA.INT = 0;
    end
    nVec++; if (busA.vectorOut !== 8'h48) begin nFail++; $display("FAIL basicVec got %h want 48", busA.vectorOut); end
    busA.vectorAck = 1;
    tick();
    busA.vectorAck = 0;
    nVec++; if (busA.vectorValid !== 1'b0) begin nFail++; $display("FAIL basicAck got %b want 0", busA.vectorValid); end
  endtask

  task automatic test_enable();
    busA.INT = 1; busA.intEnable = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      nVec++; if (busA.INTA_n !== 1'b1) begin nFail++; $display("FAIL disInta k=%0d got %b want 1", k, busA.INTA_n); end
      nVec++; if (busA.busy !== 1'b0) begin nFail++; $display("FAIL disBusy k=%0d got %b want 0", k, busA.busy); end
    end
    busA.intEnable = 1;
    tick();
    nVec++; if (busA.INTA_n !== 1'b0) begin nFail++; $display("FAIL enStartInta got %b want 0", busA.INTA_n); end
    nVec++; if (busA.busy !== 1'b1) begin nFail++; $display("FAIL enStartBusy got %b want 1", busA.busy); end
  endtask

  // Continues the sequence started by test_enable (now at edge 0).
  task automatic test_spurious();
    for (int k = 1; k <= 6; k++) begin
      tick();
      nVec++; if (busA.INTA_n !== expInta(k, 0, 2, 2)) begin nFail++; $display("FAIL spurInta k=%0d got %b want %b", k, busA.INTA_n, expInta(k, 0, 2, 2)); end
      if (k == 2) begin busA.INT = 0; busA.dataBus = 8'h4F; end
    end
    nVec++; if (busA.vectorValid !== 1'b1) begin nFail++; $display("FAIL spurValid got %b want 1", busA.vectorValid); end
    nVec++; if (busA.vectorOut !== 8'h4F) begin nFail++; $display("FAIL spurVec got %h want 4f", busA.vectorOut); end
    busA.vectorAck = 1;
    tick();
    busA.vectorAck = 0;
    nVec++; if (busA.busy !== 1'b0) begin nFail++; $display("FAIL spurAckBusy got %b want 0", busA.busy); end
    for (int k = 0; k < 5; k++) begin
      tick();
      nVec++; if (busA.INTA_n !== 1'b1 || busA.busy !== 1'b0) begin nFail++; $display("FAIL spurIdle k=%0d inta %b busy %b want 1/0", k, busA.INTA_n, busA.busy); end
    end
  endtask

  task automatic test_hold();
    busA.INT = 1; busA.dataBus = 8'h21;
    for (int k = 0; k <= SyncLat + 6; k++) tick();
    nVec++; if (busA.vectorValid !== 1'b1) begin nFail++; $display("FAIL holdEntry got %b want 1", busA.vectorValid); end
    busA.dataBus = 8'h99;
    for (int k = 0; k < 10; k++) begin
      tick();
      nVec++; if (busA.vectorValid !== 1'b1 || busA.INTA_n !== 1'b1) begin nFail++; $display("FAIL holdStay k=%0d valid %b inta %b want 1/1", k, busA.vectorValid, busA.INTA_n); end
      nVec++; if (busA.vectorOut !== 8'h21) begin nFail++; $display("FAIL holdVec k=%0d got %h want 21", k, busA.vectorOut); end
    end
    busA.vectorAck = 1;
    tick();
    busA.vectorAck = 0;
    nVec++; if (busA.vectorValid !== 1'b0 || busA.busy !== 1'b0 || busA.INTA_n !== 1'b1) begin nFail++; $display("FAIL holdAck valid %b busy %b inta %b want 0/0/1", busA.vectorValid, busA.busy, busA.INTA_n); end
    tick();
    nVec++; if (busA.INTA_n !== 1'b0 || busA.busy !== 1'b1) begin nFail++; $display("FAIL holdRestart inta %b busy %b want 0/1", busA.INTA_n, busA.busy); end
  endtask

  // Continues from edge 0 of the sequence restarted by test_hold.
  task automatic test_reset_mid();
    for (int k = 1; k <= 4; k++) tick();
    nVec++; if (busA.INTA_n !== 1'b0) begin nFail++; $display("FAIL midInAck2 got %b want 0", busA.INTA_n); end
    #2 reset = 1'b1;
    #1;
    nVec++; if (busA.INTA_n !== 1'b1) begin nFail++; $display("FAIL midRstInta got %b want 1", busA.INTA_n); end
    nVec++; if (busA.vectorValid !== 1'b0 || busA.busy !== 1'b0) begin nFail++; $display("FAIL midRstFlags valid %b busy %b want 0/0", busA.vectorValid, busA.busy); end
    nVec++; if (busA.vectorOut !== 8'h00) begin nFail++; $display("FAIL midRstVec got %h want 00", busA.vectorOut); end
    tick();
    reset = 1'b0;
    busA.dataBus = 8'h5A;
    busA.vectorAck = 1;
    for (int k = 0; k <= SyncLat + 6; k++) begin
      tick();
      nVec++; if (busA.INTA_n !== expInta(k, SyncLat, 2, 2)) begin nFail++; $display("FAIL freshInta k=%0d got %b want %b", k, busA.INTA_n, expInta(k, SyncLat, 2, 2)); end
      if (k == SyncLat + 1) busA.INT = 0;
    end
    nVec++; if (busA.vectorValid !== 1'b1) begin nFail++; $display("FAIL freshValid got %b want 1", busA.vectorValid); end
    nVec++; if (busA.vectorOut !== 8'h5A) begin nFail++; $display("FAIL freshVec got %h want 5a", busA.vectorOut); end
    tick();
    busA.vectorAck = 0;
    nVec++; if (busA.vectorValid !== 1'b0) begin nFail++; $display("FAIL freshAck got %b want 0", busA.vectorValid); end
  endtask

  task automatic test_params();
    busB.INT = 1; busB.intEnable = 1; busB.dataBus = 8'h77;
    for (int k = 0; k <= SyncLat + 7; k++) begin
      tick();
      nVec++; if (busB.INTA_n !== expInta(k, SyncLat, 3, 1)) begin nFail++; $display("FAIL parInta k=%0d got %b want %b", k, busB.INTA_n, expInta(k, SyncLat, 3, 1)); end
      nVec++; if (busB.vectorValid !== (k == SyncLat + 7)) begin nFail++; $display("FAIL parValid k=%0d got %b", k, busB.vectorValid); end
      if (k == SyncLat + 1) busB.INT = 0;
    end
    nVec++; if (busB.vectorOut !== 8'h77) begin nFail++; $display("FAIL parVec got %h want 77", busB.vectorOut); end
    busB.vectorAck = 1;
    tick();
    busB.vectorAck = 0;
    nVec++; if (busB.vectorValid !== 1'b0 || busB.busy !== 1'b0) begin nFail++; $display("FAIL parAck valid %b busy %b want 0/0", busB.vectorValid, busB.busy); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_enable();
    test_spurious();
    test_hold();
    test_reset_mid();
    test_params();
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
    $finish;
  end

endmodule

// File: doc/inta_sequencer.md
Name: inta_sequencer

Overview:
- CPU-side initiator of the 8259A interrupt-acknowledge protocol; the opposite end of the PIC's INTA/vector responder.
- Watches the PIC's INT line and, when interrupts are enabled, drives the two-pulse active-low INTA sequence on the shared bus.
- Captures the 8-bit vector that the PIC places on the data bus during the second pulse.
- Hands the vector to the core through a valid/ack handshake. Sits between the PIC data-bus buffer and the core's interrupt entry logic.

Parameters:
- PULSE_CYCLES, 2, number of clk cycles each INTA_n low pulse lasts (must be ≥1)
- GAP_CYCLES, 2, number of clk cycles INTA_n is high between the two pulses (must be ≥1)

Ports:
- clk  input  1  system clock; all state changes on its rising edge
- reset  input  1  asynchronous, active-high reset
- INT  input  1  interrupt request from the PIC, active high
- intEnable  input  1  core interrupt-enable flag; a new sequence starts only while this is 1
- dataBus  input  8  PIC data-bus output, sampled during the second INTA pulse
- vectorAck  input  1  core has consumed vectorOut
- INTA_n  output  1  interrupt acknowledge to the PIC, active low
- vectorOut  output  8  captured interrupt vector
- vectorValid  output  1  vectorOut holds a vector not yet acknowledged
- busy  output  1  high in every state except IDLE

Behaviour:
- Reset values (asynchronous): state=IDLE, INTA_n=1, vectorOut=8'h00, vectorValid=0, busy=0, counters=0.
- States: IDLE, ACK1, GAP, ACK2, HOLD.
- IDLE:
  - If INT=1 and intEnable=1 at a rising edge, go to ACK1, load the counter, and drive INTA_n=0 from that edge.
  - Otherwise stay in IDLE.
- ACK1: INTA_n=0 for exactly PULSE_CYCLES cycles, then go to GAP with INTA_n=1.
- GAP: INTA_n=1 for exactly GAP_CYCLES cycles, then go to ACK2 with INTA_n=0.
- ACK2: INTA_n=0 for exactly PULSE_CYCLES cycles. On the final edge of ACK2, in a single edge:
  - register dataBus into vectorOut
  - set INTA_n=1
  - set vectorValid=1
  - go to HOLD
- HOLD:
  - vectorOut is stable and vectorValid=1.
  - On the edge where vectorAck=1, clear vectorValid and go to IDLE.
- Latency: vectorValid rises 2*PULSE_CYCLES+GAP_CYCLES edges after the IDLE edge that sampled INT. With defaults this is 6 edges.
- Counters: width $clog2(max(PULSE_CYCLES,GAP_CYCLES))+1; each counts down to 1, then the state advances.
- Commitment: once ACK1 is entered, the full sequence always completes. A change in INT or intEnable does not abort it (the PIC expects two pulses). If INT dropped, the PIC supplies a spurious IR7 vector, which is captured like any other vector.
- vectorAck outside HOLD: ignored.
- vectorAck already high on the HOLD entry edge: not consumed. The ack must be sampled while in HOLD, so the minimum HOLD residency is 1 cycle.
- Back-to-back interrupts: after HOLD→IDLE, at least one IDLE cycle elapses before the next INT sample. Back-to-back INTA sequences are therefore separated by ≥1 cycle with INTA_n=1.
- intEnable=0 in IDLE: INT is ignored; the block stays in IDLE with busy=0.
- Reset mid-sequence: INTA_n returns to 1 immediately (asynchronously), vectorValid clears, and any partial vector is discarded.
- Between captures, vectorOut keeps its last value; it changes only at the ACK2 capture edge or on reset.

Optional Feature:
- Macro: INTA_INT_SYNC_EN.
- Defined: INT passes through a two-flop synchronizer before IDLE samples it. This adds exactly 2 cycles of start latency, so vectorValid rises 2*PULSE_CYCLES+GAP_CYCLES+2 edges after INT first rises. The synchronizer resets to 0.
- Undefined: INT is sampled directly, with the latency given under Behaviour.
- All other behaviour is identical in both builds.

Test Plan:
- Defaults, intEnable=1, INT rises, dataBus=8'h48 during ACK2 → INTA_n low edges 0–1, high 2–3, low 4–5; vectorValid=1 and vectorOut=8'h48 at edge 6; busy=1 from edge 0.
- intEnable=0 with INT=1 for 20 cycles → INTA_n stays 1, busy=0. Raise intEnable → sequence starts on the next edge.
- INT drops during GAP, dataBus=8'h4F → both pulses still complete; vectorOut=8'h4F (spurious IR7); vectorAck returns the block to IDLE, and with INT=0 it stays idle.
- Hold vectorAck=0 for 10 cycles in HOLD with INT still high → vectorValid stays 1, no new INTA_n pulse. Pulse vectorAck → vectorValid=0; ≥1 idle cycle, then a new sequence starts.
- Assert reset during ACK2 → INTA_n=1 and vectorValid=0 immediately; vectorOut=8'h00. After release with INT=1, a fresh full sequence runs.
- PULSE_CYCLES=3, GAP_CYCLES=1, build with INTA_INT_SYNC_EN → low pulses are 3 cycles, gap is 1 cycle, and vectorValid rises 9 edges after INT rises.
